// File: rtl/icache_inv_queue_pkg.sv
// Shared types for the instruction-side invalidation path: CPU config, queued request and FSM state.
package icache_inv_queue_pkg;

    typedef struct packed {
        int unsigned INSTR_INV_QUEUE_DEPTH;
        int unsigned ICACHE_LINE_W;          // words per icache line
        logic        INSTRUCTION_COHERENCY;  // gates instantiation of icache_inv_queue in the parent
    } cpu_config_t;

    localparam cpu_config_t CPU_CFG = '{
        INSTR_INV_QUEUE_DEPTH: 32'd4,
        ICACHE_LINE_W:         32'd4,
        INSTRUCTION_COHERENCY: 1'b1
    };

    localparam int INV_LINE_ADDR_W = 32 - 2 - $clog2(CPU_CFG.ICACHE_LINE_W);

    typedef struct packed {
        logic [INV_LINE_ADDR_W-1:0] line_addr;
        logic                       all;
    } instr_inv_t;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FLUSH  = 1'b1
    } inv_state_t;

endpackage

// File: rtl/icache_inv_fifo.sv
// Circular store for pending invalidation lines, exposing head and tail for dispatch and coalescing.
// Latency: a push is visible at the head the next cycle; no backpressure, the caller never pushes into a full queue without popping.
module icache_inv_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 28
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_dat,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head_dat,
    output logic [WIDTH-1:0]         o_tail_dat,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W:0]   r_count;
    logic [PTR_W-1:0] w_tail_ptr;

    assign w_tail_ptr = r_wptr - 1'b1;
    assign o_head_dat = r_mem[r_rptr];
    assign o_tail_dat = r_mem[w_tail_ptr];
    assign o_count    = r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_clr) r_mem[r_wptr] <= i_push_dat;
    end

endmodule

// File: rtl/icache_inv_queue.sv
// Queues store-side line invalidations and forks each one to the icache and branch predictor.
// Latency: 1 cycle to both consumers; inv_valid is never stalled, an overflow degrades to a full-invalidate flush.
module icache_inv_queue
    import icache_inv_queue_pkg::*;
#(
    parameter int DEPTH       = CPU_CFG.INSTR_INV_QUEUE_DEPTH,
    parameter int LINE_ADDR_W = INV_LINE_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inv_valid,
    input  logic [31:0]            inv_addr,
    output logic                   ic_inv_valid,
    output logic [LINE_ADDR_W-1:0] ic_inv_addr,
    output logic                   ic_inv_all,
    input  logic                   ic_inv_ack,
    output logic                   bp_inv_valid,
    output logic [LINE_ADDR_W-1:0] bp_inv_addr,
    output logic                   bp_inv_all,
    input  logic                   bp_inv_ack,
    output logic                   busy
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    inv_state_t             r_state;
    logic                   r_ic_done;
    logic                   r_bp_done;

    logic [LINE_ADDR_W-1:0] w_line;
    logic [LINE_ADDR_W-1:0] w_head_dat;
    logic [LINE_ADDR_W-1:0] w_tail_dat;
    logic [CNT_W-1:0]       w_count;
    logic                   w_flush;
    logic                   w_full;
    logic                   w_req_vld;
    logic                   w_ic_fin;
    logic                   w_bp_fin;
    logic                   w_req_done;
    logic                   w_pop;
    logic                   w_coalesce;
    logic                   w_enq_ok;
    logic                   w_want;
    logic                   w_overflow;
    logic                   w_push;
    logic                   w_unused_addr;
    instr_inv_t             w_req;

    assign w_line        = inv_addr[31 -: LINE_ADDR_W];
    assign w_unused_addr = ^inv_addr[31-LINE_ADDR_W:0];

    assign w_flush    = (r_state == ST_FLUSH);
    assign w_full     = (w_count == CNT_W'(DEPTH));
    assign w_req_vld  = w_flush | (w_count != '0);

    assign ic_inv_valid = w_req_vld & ~r_ic_done;
    assign bp_inv_valid = w_req_vld & ~r_bp_done;

    // A consumer is finished once it has acked, including an ack in the current cycle.
    assign w_ic_fin   = r_ic_done | (ic_inv_valid & ic_inv_ack);
    assign w_bp_fin   = r_bp_done | (bp_inv_valid & bp_inv_ack);
    assign w_req_done = w_req_vld & w_ic_fin & w_bp_fin;
    assign w_pop      = ~w_flush & w_req_done;

    // Only the tail can absorb a repeat, and never while it is the head already in flight.
    assign w_coalesce = (w_count >= CNT_W'(2)) & (w_line == w_tail_dat);
    // Before any flush ack the pending invalidate-all still covers the new line.
    assign w_enq_ok   = ~w_flush | w_ic_fin | w_bp_fin;
    assign w_want     = inv_valid & ~w_coalesce & w_enq_ok;
    assign w_overflow = w_want & w_full & ~w_pop;
    assign w_push     = w_want & ~w_overflow;

    icache_inv_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (LINE_ADDR_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_overflow),
        .i_push     (w_push),
        .i_push_dat (w_line),
        .i_pop      (w_pop),
        .o_head_dat (w_head_dat),
        .o_tail_dat (w_tail_dat),
        .o_count    (w_count)
    );

    always_comb begin
        w_req.line_addr = '0;
        w_req.all       = w_flush;
        if (!w_flush && (w_count != '0)) w_req.line_addr = INV_LINE_ADDR_W'(w_head_dat);
    end

    assign ic_inv_addr = LINE_ADDR_W'(w_req.line_addr);
    assign bp_inv_addr = LINE_ADDR_W'(w_req.line_addr);
    assign ic_inv_all  = w_req.all & ~r_ic_done;
    assign bp_inv_all  = w_req.all & ~r_bp_done;
    assign busy        = w_req_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_NORMAL;
            r_ic_done <= 1'b0;
            r_bp_done <= 1'b0;
        end else if (w_overflow) begin
            r_state   <= ST_FLUSH;
            r_ic_done <= 1'b0;
            r_bp_done <= 1'b0;
        end else if (w_req_done) begin
            r_state   <= ST_NORMAL;
            r_ic_done <= 1'b0;
            r_bp_done <= 1'b0;
        end else begin
            r_ic_done <= w_ic_fin;
            r_bp_done <= w_bp_fin;
        end
    end

endmodule

// File: tb/tb_icache_inv_queue.sv
// Directed bench for icache_inv_queue: fork/ack, coalescing, overflow flush, flush window, full-with-pop, reset.
module tb_icache_inv_queue;

    localparam int LW = 28;

    logic          clk = 1'b0;
    logic          rst;
    logic          inv_valid;
    logic [31:0]   inv_addr;
    logic          ic_inv_valid;
    logic [LW-1:0] ic_inv_addr;
    logic          ic_inv_all;
    logic          ic_inv_ack;
    logic          bp_inv_valid;
    logic [LW-1:0] bp_inv_addr;
    logic          bp_inv_all;
    logic          bp_inv_ack;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    icache_inv_queue #(
        .DEPTH       (4),
        .LINE_ADDR_W (LW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inv_valid    (inv_valid),
        .inv_addr     (inv_addr),
        .ic_inv_valid (ic_inv_valid),
        .ic_inv_addr  (ic_inv_addr),
        .ic_inv_all   (ic_inv_all),
        .ic_inv_ack   (ic_inv_ack),
        .bp_inv_valid (bp_inv_valid),
        .bp_inv_addr  (bp_inv_addr),
        .bp_inv_all   (bp_inv_all),
        .bp_inv_ack   (bp_inv_ack),
        .busy         (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Flags packed as {ic_valid, bp_valid, ic_all, bp_all, busy}.
    task automatic chk_out(input string tag, input logic [4:0] exp_flags, input logic [31:0] exp_addr);
        chk({tag, "/flags"}, {27'd0, ic_inv_valid, bp_inv_valid, ic_inv_all, bp_inv_all, busy}, {27'd0, exp_flags});
        chk({tag, "/ic_addr"}, 32'(ic_inv_addr), exp_addr);
        chk({tag, "/bp_addr"}, 32'(bp_inv_addr), exp_addr);
    endtask

    task automatic req(input logic [31:0] a);
        inv_valid = 1'b1;
        inv_addr  = a;
        tick();
        inv_valid = 1'b0;
        inv_addr  = 32'd0;
    endtask

    task automatic drain_one(input string tag, input logic [31:0] exp_addr);
        ic_inv_ack = 1'b1;
        bp_inv_ack = 1'b1;
        chk_out(tag, 5'b11001, exp_addr);
        tick();
        ic_inv_ack = 1'b0;
        bp_inv_ack = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        inv_valid  = 1'b0;
        inv_addr   = 32'd0;
        ic_inv_ack = 1'b0;
        bp_inv_ack = 1'b0;
        tick();
        tick();
        chk_out("reset_hold", 5'b00000, 32'h0);
        rst = 1'b0;
        tick();
        chk_out("reset_idle", 5'b00000, 32'h0);

        // Single request: fork, independent acks, pop on the later ack.
        inv_valid = 1'b1;
        inv_addr  = 32'h8000_1234;
        chk_out("single_c0", 5'b00000, 32'h0);
        tick();
        inv_valid = 1'b0;
        chk_out("single_c1", 5'b11001, 32'h0800_0123);
        tick();
        ic_inv_ack = 1'b1;
        chk_out("single_c2", 5'b11001, 32'h0800_0123);
        tick();
        ic_inv_ack = 1'b0;
        chk_out("single_c3", 5'b01001, 32'h0800_0123);
        tick();
        bp_inv_ack = 1'b1;
        chk_out("single_c4", 5'b01001, 32'h0800_0123);
        tick();
        bp_inv_ack = 1'b0;
        chk_out("single_c5", 5'b00000, 32'h0);

        // Coalescing with consumers stalled: the fourth request repeats the tail and is dropped.
        req(32'h8000_0010);
        req(32'h8000_0020);
        req(32'h8000_0014);
        req(32'h8000_001C);
        drain_one("coal_e0", 32'h0800_0001);
        drain_one("coal_e1", 32'h0800_0002);
        drain_one("coal_e2", 32'h0800_0001);
        chk_out("coal_empty", 5'b00000, 32'h0);

        // A repeat of the head itself is still enqueued.
        req(32'h8000_0040);
        req(32'h8000_0044);
        drain_one("headmatch_e0", 32'h0800_0004);
        drain_one("headmatch_e1", 32'h0800_0004);
        chk_out("headmatch_empty", 5'b00000, 32'h0);

        // Overflow into FLUSH, then the flush window.
        req(32'h0000_0100);
        req(32'h0000_0200);
        req(32'h0000_0300);
        req(32'h0000_0400);
        chk_out("ovf_full", 5'b11001, 32'h10);
        req(32'h0000_0500);
        chk_out("ovf_flush", 5'b11111, 32'h0);
        req(32'h0000_0600);
        chk_out("win_pre_ack", 5'b11111, 32'h0);
        ic_inv_ack = 1'b1;
        tick();
        ic_inv_ack = 1'b0;
        chk_out("win_ic_acked", 5'b01011, 32'h0);
        req(32'h0000_0700);
        bp_inv_ack = 1'b1;
        chk_out("win_bp_ack", 5'b01011, 32'h0);
        tick();
        bp_inv_ack = 1'b0;
        drain_one("win_queued", 32'h70);
        chk_out("win_empty", 5'b00000, 32'h0);

        // Full queue with a pop and an enqueue in the same cycle stays NORMAL.
        req(32'h0000_1000);
        req(32'h0000_2000);
        req(32'h0000_3000);
        req(32'h0000_4000);
        ic_inv_ack = 1'b1;
        bp_inv_ack = 1'b1;
        inv_valid  = 1'b1;
        inv_addr   = 32'h0000_5000;
        chk_out("fullpop_c0", 5'b11001, 32'h100);
        tick();
        ic_inv_ack = 1'b0;
        bp_inv_ack = 1'b0;
        inv_valid  = 1'b0;
        chk_out("fullpop_c1", 5'b11001, 32'h200);
        drain_one("fullpop_e0", 32'h200);
        drain_one("fullpop_e1", 32'h300);
        drain_one("fullpop_e2", 32'h400);
        drain_one("fullpop_e3", 32'h500);
        chk_out("fullpop_empty", 5'b00000, 32'h0);

        // Reset while in FLUSH with two entries queued behind the flush.
        req(32'h0000_A100);
        req(32'h0000_A200);
        req(32'h0000_A300);
        req(32'h0000_A400);
        req(32'h0000_A500);
        ic_inv_ack = 1'b1;
        tick();
        ic_inv_ack = 1'b0;
        req(32'h0000_B000);
        req(32'h0000_C000);
        chk_out("rstflush_pre", 5'b01011, 32'h0);
        rst = 1'b1;
        tick();
        chk_out("rstflush_c1", 5'b00000, 32'h0);
        rst = 1'b0;
        tick();
        tick();
        chk_out("rstflush_idle", 5'b00000, 32'h0);
        req(32'h0000_D000);
        chk_out("rstflush_new", 5'b11001, 32'hD00);
        drain_one("rstflush_drain", 32'hD00);
        chk_out("rstflush_empty", 5'b00000, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
